// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, stall encoding,
// load-opcode bit positions and the packed layouts of the EX->MEM and
// MEM->WB buses.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 147;
    localparam int MEM_TO_WB_WD = 136;
    localparam int STALL_BUS_W  = 6;

    // Stall vector bit positions owned by this stage
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // One-hot load opcode bit indices, shared with ID/EX
    localparam int OP_LOAD_LW  = 0;
    localparam int OP_LOAD_LB  = 1;
    localparam int OP_LOAD_LBU = 2;
    localparam int OP_LOAD_LH  = 3;
    localparam int OP_LOAD_LHU = 4;

    typedef struct packed {
        logic [4:0]  op_load;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_result;
        logic [31:0] lo_result;
        logic [31:0] ex_pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_result;
        logic [31:0] lo_result;
        logic [31:0] mem_pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU
    } load_kind_e;

    // Collapse the (nominally one-hot) opcode into a single load kind.
    // A multi-hot opcode is illegal; the fixed priority lw>lb>lbu>lh>lhu
    // keeps the result deterministic anyway.
    function automatic load_kind_e decode_load(input logic [4:0] op_load);
        if (op_load[OP_LOAD_LW])  return LD_W;
        if (op_load[OP_LOAD_LB])  return LD_B;
        if (op_load[OP_LOAD_LBU]) return LD_BU;
        if (op_load[OP_LOAD_LH])  return LD_H;
        if (op_load[OP_LOAD_LHU]) return LD_HU;
        return LD_NONE;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// SRAM word and sign- or zero-extends it to 32 bits.
// Optional macro MEM_ALIGN_CHECK_EN adds the misaligned-address flag adel.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  op_load,
    input  logic [1:0]  off,
    input  logic [31:0] ld_word,
    output logic [31:0] aligned
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        adel
`endif
);

    logic [7:0]  byte_lanes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    load_kind_e  kind;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lanes[gi] = ld_word[8*gi +: 8];
        end
    endgenerate

    assign kind     = decode_load(op_load);
    assign sel_byte = byte_lanes[off];
    // Halfword choice looks only at off[1]; off[0] is ignored (or flagged)
    assign sel_half = off[1] ? ld_word[31:16] : ld_word[15:0];

    // Extend the selected lane according to the load kind; lw passes through
    always_comb begin
        aligned = ld_word;
        case (kind)
            LD_B:    aligned = {{24{sel_byte[7]}}, sel_byte};
            LD_BU:   aligned = {24'h00_0000, sel_byte};
            LD_H:    aligned = {{16{sel_half[15]}}, sel_half};
            LD_HU:   aligned = {16'h0000, sel_half};
            default: aligned = ld_word;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Word loads need off==0, halfword loads need an even offset
    always_comb begin
        adel = ((kind == LD_W) && (off != 2'b00)) ||
               (((kind == LD_H) || (kind == LD_HU)) && off[0]);
    end
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, captures the 1-cycle SRAM
// read data (holding it across stalls), aligns load data and drives the
// MEM->WB bus plus an identical MEM->ID forwarding copy.
// Optional macro MEM_ALIGN_CHECK_EN adds the mem_adel output and suppresses
// the register write of a misaligned load.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_BUS_W-1:0]   stall,
    input  logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    input  logic [31:0]              data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_id_forwarding
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                     mem_adel
`endif
);

    ex_to_mem_t  r_reg;
    logic        fresh_reg;
    logic [31:0] held_rdata_reg;

    logic        stop_ex_mem;
    logic        stop_mem_wb;
    logic [31:0] ld_word;
    logic [31:0] aligned;
    logic        adel;
    mem_to_wb_t  wb;

    assign stop_ex_mem = (stall[STALL_EX_MEM] == STOP);
    assign stop_mem_wb = (stall[STALL_MEM_WB] == STOP);

    // EX/MEM register: bubble when EX stops but WB moves on, load when EX moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg <= '0;
        end else if (stop_ex_mem && !stop_mem_wb) begin
            r_reg <= '0;
        end else if (!stop_ex_mem) begin
            r_reg <= ex_to_mem_bus;
        end
    end

    // fresh marks the single cycle in which the SRAM read data belongs to r_reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fresh_reg <= 1'b0;
        end else begin
            fresh_reg <= !stop_ex_mem;
        end
    end

    // Capture the SRAM word while it is valid so a stalled load keeps it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_rdata_reg <= ZERO_WORD;
        end else if (fresh_reg) begin
            held_rdata_reg <= data_sram_rdata;
        end
    end

    assign ld_word = fresh_reg ? data_sram_rdata : held_rdata_reg;

    mem_stage_load_align u_load_align (
        .op_load (r_reg.op_load),
        .off     (r_reg.ex_result[1:0]),
        .ld_word (ld_word),
        .aligned (aligned)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .adel    (adel)
`endif
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign adel = 1'b0;
`endif

    // Assemble the MEM->WB bus; a misaligned load never writes the register file
    always_comb begin
        wb           = '0;
        wb.hi_we     = r_reg.hi_we;
        wb.lo_we     = r_reg.lo_we;
        wb.hi_result = r_reg.hi_result;
        wb.lo_result = r_reg.lo_result;
        wb.mem_pc    = r_reg.ex_pc;
        wb.rf_we     = r_reg.rf_we & ~adel;
        wb.rf_waddr  = r_reg.rf_waddr;
        wb.rf_wdata  = (r_reg.sel_rf_res && (|r_reg.op_load)) ? aligned : r_reg.ex_result;
    end

    assign mem_to_wb_bus        = wb;
    assign mem_to_id_forwarding = wb;

`ifdef MEM_ALIGN_CHECK_EN
    assign mem_adel = adel;
`endif

    // Store controls and the other stages' stall bits are consumed elsewhere
    logic unused_bits;
    assign unused_bits = ^{r_reg.data_ram_en, r_reg.data_ram_wen,
                           stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of single-load vectors plus
// hand-written stall, bubble and asynchronous-reset sequences. Expected
// MEM->WB words are queued when stimulus is driven and compared on the
// falling edge after the DUT produces them.
`timescale 1ns/1ps
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [146:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [135:0] mem_to_id_forwarding;
`ifdef MEM_ALIGN_CHECK_EN
    logic         mem_adel;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .ex_to_mem_bus        (ex_to_mem_bus),
        .data_sram_rdata      (data_sram_rdata),
        .mem_to_wb_bus        (mem_to_wb_bus),
        .mem_to_id_forwarding (mem_to_id_forwarding)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .mem_adel             (mem_adel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [3:0]  wen;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic [31:0] ex_result;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic        exp_adel;
    } vec_t;

    typedef struct {
        string        name;
        logic [135:0] bus;
        logic         adel;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string n, logic [4:0] op, logic sel, logic we,
                                logic [31:0] ex_result, logic [31:0] rdata,
                                logic [31:0] exp_wdata, logic exp_adel);
        vec_t v;
        v.name      = n;
        v.op        = op;
        v.sel       = sel;
        v.we        = we;
        v.waddr     = 5'd7;
        v.wen       = 4'h0;
        v.hi_we     = 1'b0;
        v.lo_we     = 1'b0;
        v.hi        = 32'h0;
        v.lo        = 32'h0;
        v.pc        = ex_result ^ 32'hBFC0_0000;
        v.ex_result = ex_result;
        v.rdata     = rdata;
        v.exp_wdata = exp_wdata;
        v.exp_adel  = exp_adel;
        return v;
    endfunction

    function automatic logic [146:0] pack_ex(vec_t v);
        return {v.op, v.hi_we, v.lo_we, v.hi, v.lo, v.pc,
                (|v.op) | (|v.wen), v.wen, v.sel, v.we, v.waddr, v.ex_result};
    endfunction

    function automatic exp_t exp_of(vec_t v);
        exp_t e;
        logic we_exp;
`ifdef MEM_ALIGN_CHECK_EN
        we_exp = v.we & ~v.exp_adel;
`else
        we_exp = v.we;
`endif
        e.name = v.name;
        e.bus  = {v.hi_we, v.lo_we, v.hi, v.lo, v.pc, we_exp, v.waddr, v.exp_wdata};
        e.adel = v.exp_adel;
        return e;
    endfunction

    function automatic exp_t exp_zero(string n);
        exp_t e;
        e.name = n;
        e.bus  = '0;
        e.adel = 1'b0;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (mem_to_wb_bus !== e.bus) begin
            errors++;
            $display("FAIL %s wb_bus: got %h required %h", e.name, mem_to_wb_bus, e.bus);
        end
        checks++;
        if (mem_to_id_forwarding !== e.bus) begin
            errors++;
            $display("FAIL %s fwd_bus: got %h required %h", e.name, mem_to_id_forwarding, e.bus);
        end
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (mem_adel !== e.adel) begin
            errors++;
            $display("FAIL %s mem_adel: got %b required %b", e.name, mem_adel, e.adel);
        end
`endif
        $display("txn %-14s rf_we=%b rf_wdata=%h", e.name, mem_to_wb_bus[37], mem_to_wb_bus[31:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t addu;

        vecs.push_back(mk("lb_off3",     5'b00010, 1, 1, 32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80, 0));
        vecs.push_back(mk("lbu_off3",    5'b00100, 1, 1, 32'h1000_0003, 32'h80FF_1234, 32'h0000_0080, 0));
        vecs.push_back(mk("lh_off2",     5'b01000, 1, 1, 32'h1000_0002, 32'h8001_7FFF, 32'hFFFF_8001, 0));
        vecs.push_back(mk("lhu_off0",    5'b10000, 1, 1, 32'h1000_0000, 32'h8001_7FFF, 32'h0000_7FFF, 0));
        vecs.push_back(mk("lw_off0",     5'b00001, 1, 1, 32'h2000_0000, 32'h1234_5678, 32'h1234_5678, 0));
        vecs.push_back(mk("lb_off0",     5'b00010, 1, 1, 32'h1000_0010, 32'h80FF_1234, 32'h0000_0034, 0));
        vecs.push_back(mk("lb_off1",     5'b00010, 1, 1, 32'h1000_0011, 32'h80FF_1234, 32'h0000_0012, 0));
        vecs.push_back(mk("lb_off2",     5'b00010, 1, 1, 32'h1000_0012, 32'h80FF_1234, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk("lbu_off2",    5'b00100, 1, 1, 32'h1000_0012, 32'h80FF_1234, 32'h0000_00FF, 0));
        vecs.push_back(mk("lhu_off2",    5'b10000, 1, 1, 32'h1000_0022, 32'h8001_7FFF, 32'h0000_8001, 0));
        vecs.push_back(mk("lh_off0",     5'b01000, 1, 1, 32'h1000_0020, 32'h0000_8000, 32'hFFFF_8000, 0));
        vecs.push_back(mk("addu",        5'b00000, 0, 1, 32'h0000_0042, 32'hFFFF_FFFF, 32'h0000_0042, 0));
        vecs.push_back(mk("lw_sel0",     5'b00001, 0, 1, 32'h1000_0004, 32'hCAFE_F00D, 32'h1000_0004, 0));
        v = mk("store", 5'b00000, 0, 0, 32'h1000_0008, 32'h0BAD_0BAD, 32'h1000_0008, 0);
        v.wen = 4'hF;
        vecs.push_back(v);
        v = mk("hilo", 5'b00000, 0, 0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0);
        v.hi_we = 1'b1;
        v.lo_we = 1'b1;
        v.hi    = 32'hAAAA_0001;
        v.lo    = 32'h5555_0002;
        vecs.push_back(v);
        vecs.push_back(mk("mh_lb_lbu",   5'b00110, 1, 1, 32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80, 0));
        vecs.push_back(mk("mh_lh_lhu",   5'b11000, 1, 1, 32'h1000_0002, 32'h8001_7FFF, 32'hFFFF_8001, 0));
        vecs.push_back(mk("mh_lw_lb",    5'b00011, 1, 1, 32'h1000_0000, 32'h80FF_1234, 32'h80FF_1234, 0));
        vecs.push_back(mk("lw_off2",     5'b00001, 1, 1, 32'h1000_0002, 32'h1234_5678, 32'h1234_5678, 1));
        vecs.push_back(mk("lh_off1",     5'b01000, 1, 1, 32'h1000_0001, 32'h8001_7FFF, 32'h0000_7FFF, 1));
        vecs.push_back(mk("lhu_off3",    5'b10000, 1, 1, 32'h1000_0003, 32'h8001_7FFF, 32'h0000_8001, 1));

        // Reset state
        rst             = 1'b1;
        stall           = 6'b0;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'h0;
        repeat (2) @(negedge clk);
        sb.push_back(exp_zero("reset"));
        check_out();
        rst = 1'b0;

        // Table-driven single loads/ALU ops
        for (int i = 0; i < vecs.size(); i++) begin
            stall         = 6'b0;
            ex_to_mem_bus = pack_ex(vecs[i]);
            @(posedge clk);
            #1;
            data_sram_rdata = vecs[i].rdata;
            ex_to_mem_bus   = '0;
            sb.push_back(exp_of(vecs[i]));
            @(negedge clk);
            check_out();
        end

        // Stalled lw: SRAM data changes but WB must keep the original word
        v    = mk("lw_stall", 5'b00001, 1, 1, 32'h2000_0010, 32'h1234_5678, 32'h1234_5678, 0);
        addu = mk("addu_after", 5'b00000, 0, 1, 32'h0000_0042, 32'h0, 32'h0000_0042, 0);
        addu.waddr = 5'd9;
        stall         = 6'b0;
        ex_to_mem_bus = pack_ex(v);
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h1234_5678;
        stall           = 6'b011000;
        ex_to_mem_bus   = pack_ex(addu);
        sb.push_back(exp_of(v));
        @(negedge clk);
        check_out();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            data_sram_rdata = 32'hDEAD_BEEF;
            sb.push_back(exp_of(v));
            @(negedge clk);
            check_out();
        end

        // Release: the waiting addu enters
        stall = 6'b0;
        @(posedge clk);
        #1;
        sb.push_back(exp_of(addu));
        @(negedge clk);
        check_out();

        // EX stops while WB runs: bubble regardless of the incoming bus
        stall         = 6'b001000;
        ex_to_mem_bus = pack_ex(vecs[0]);
        @(posedge clk);
        #1;
        sb.push_back(exp_zero("bubble"));
        @(negedge clk);
        check_out();
        stall         = 6'b0;
        ex_to_mem_bus = '0;

        // Asynchronous reset in the middle of a cycle holding a load
        v = mk("lw_pre_rst", 5'b00001, 1, 1, 32'h3000_0000, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 0);
        ex_to_mem_bus = pack_ex(v);
        @(posedge clk);
        #1;
        data_sram_rdata = 32'hA5A5_5A5A;
        ex_to_mem_bus   = '0;
        #1;
        sb.push_back(exp_of(v));
        check_out();
        #1;
        rst = 1'b1;
        #1;
        sb.push_back(exp_zero("async_rst"));
        check_out();
        @(negedge clk);
        rst   = 1'b0;
        stall = 6'b011000;
        @(posedge clk);
        #1;
        sb.push_back(exp_zero("post_rst_hold"));
        @(negedge clk);
        check_out();
        stall = 6'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
